// File: rtl/fpadd_issue_ctrl.sv
// fpadd_issue_ctrl: valid/ready issue and capture wrapper around fpadd_single.
// Holds operands for LAT clocks, then presents the classified sum downstream.
module fpadd_issue_ctrl #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [3:0]  res_flags,
    output logic [15:0] txn_count
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       accept, cap, pop;
    logic [3:0] flags;
    always_comb begin
        in_ready = (state == IDLE) || (state == HOLD && res_ready);
        accept   = in_valid && in_ready;
        cap      = (state == WAIT) && (cnt == 4'(LAT));
        pop      = (state == HOLD) && res_ready;
        state_nx = accept ? WAIT : cap ? HOLD : pop ? IDLE : state;
        flags    = {add_out[30:23] == 8'hFF && add_out[22:0] != 0,
                    add_out[30:23] == 8'hFF && add_out[22:0] == 0,
                    add_out[30:23] == 8'h00 && add_out[22:0] == 0,
                    add_out[30:23] == 8'h00 && add_out[22:0] != 0};
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            res_data  <= '0;
            res_flags <= '0;
            res_valid <= 1'b0;
            txn_count <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                add_a <= in_a;
                add_b <= in_b;
                cnt   <= 4'd1;
            end else if (state == WAIT && !cap) begin
                cnt <= cnt + 4'd1;
            end
            if (cap) begin
                res_data  <= add_out;
                res_flags <= flags;
                res_valid <= 1'b1;
            end
            if (pop) begin
                res_valid <= 1'b0;
                txn_count <= txn_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_fpadd_issue_ctrl.sv
// tb_fpadd_issue_ctrl: directed bench with a one-cycle registered adder stand-in
// and a result scoreboard checked at every downstream handshake.
module tb_fpadd_issue_ctrl;
    logic        clk = 0;
    logic        reset = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] in_a = 0;
    logic [31:0] in_b = 0;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_out = 0;
    logic        res_valid;
    logic        res_ready = 0;
    logic [31:0] res_data;
    logic [3:0]  res_flags;
    logic [15:0] txn_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [35:0] q[$];

    fpadd_issue_ctrl #(.LAT(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_out(add_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_flags(res_flags), .txn_count(txn_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Known sums for the directed cases, an arbitrary pure function otherwise.
    function automatic logic [31:0] fref(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return 32'h40400000;
            64'h7F800000_3F800000: return 32'h7F800000;
            64'h3F800000_BF800000: return 32'h00000000;
            64'h00000001_00000001: return 32'h00000002;
            64'h7FC00000_3F800000: return 32'h7FC00000;
            default:               return a ^ {b[22:0], b[31:23]} ^ 32'h1234_5678;
        endcase
    endfunction

    function automatic logic [3:0] cls(input logic [31:0] v);
        logic [7:0]  e;
        logic [22:0] m;
        e = v[30:23];
        m = v[22:0];
        if (e == 8'hFF) return (m != 0) ? 4'b1000 : 4'b0100;
        if (e == 8'h00) return (m != 0) ? 4'b0001 : 4'b0010;
        return 4'b0000;
    endfunction

    always @(posedge clk) add_out <= fref(add_a, add_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && res_valid && res_ready) begin
            if (q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                logic [35:0] e;
                e = q.pop_front();
                check("res_data", res_data, e[35:4]);
                check("res_flags", {28'd0, res_flags}, {28'd0, e[3:0]});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, output int t);
        logic ok;
        in_a = a;
        in_b = b;
        in_valid = 1;
        q.push_back({fref(a, b), cls(fref(a, b))});
        t = -1;
        for (int i = 0; i < 40; i++) begin
            ok = in_ready;
            tick();
            if (ok) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("accept_timeout", 32'd1, 32'd0);
        in_valid = 0;
    endtask

    task automatic wait_valid;
        int i;
        for (i = 0; i < 40 && !res_valid; i++) tick();
        if (!res_valid) check("valid_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t, tp, base;
        logic [31:0] d, a, b;
        tick();
        tick();
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_res_valid", {31'd0, res_valid}, 0);
        check("rst_res_data", res_data, 0);
        check("rst_txn", {16'd0, txn_count}, 0);
        reset = 1;
        tick();
        check("idle_in_ready", {31'd0, in_ready}, 1);

        // Latency: accept at E, result valid after E+2
        send(32'h3F800000, 32'h40000000, t);
        check("add_a_launch", add_a, 32'h3F800000);
        check("add_b_launch", add_b, 32'h40000000);
        check("valid_E0", {31'd0, res_valid}, 0);
        tick();
        check("valid_E1", {31'd0, res_valid}, 0);
        tick();
        check("valid_E2", {31'd0, res_valid}, 1);
        check("hold_in_ready_lo", {31'd0, in_ready}, 0);
        res_ready = 1;
        #1;
        check("hold_in_ready_hi", {31'd0, in_ready}, 1);
        tick();
        check("valid_after_pop", {31'd0, res_valid}, 0);
        check("txn_1", {16'd0, txn_count}, 1);

        send(32'h7F800000, 32'h3F800000, t);
        wait_valid();
        tick();
        send(32'h3F800000, 32'hBF800000, t);
        wait_valid();
        tick();

        // Backpressure with a pending pair
        res_ready = 0;
        send(32'h3F800000, 32'h40000000, t);
        wait_valid();
        d = res_data;
        in_a = 32'h00000001;
        in_b = 32'h00000001;
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", {31'd0, res_valid}, 1);
            check("bp_data", res_data, d);
            check("bp_in_ready", {31'd0, in_ready}, 0);
            check("bp_add_a", add_a, 32'h3F800000);
            check("bp_add_b", add_b, 32'h40000000);
        end
        q.push_back({32'h00000002, 4'b0001});
        res_ready = 1;
        #1;
        check("bp_release_ready", {31'd0, in_ready}, 1);
        tick();
        in_valid = 0;
        check("bp_new_add_a", add_a, 32'h00000001);
        check("bp_new_valid", {31'd0, res_valid}, 0);
        wait_valid();
        tick();
        check("txn_5", {16'd0, txn_count}, 5);

        // Streaming: one accept every LAT+1 clocks
        base = txn_count;
        tp = 0;
        for (int i = 0; i < 10; i++) begin
            case (i % 5)
                0: begin a = 32'h3F800000; b = 32'h40000000; end
                1: begin a = 32'h7FC00000; b = 32'h3F800000; end
                2: begin a = 32'h00000001; b = 32'h00000001; end
                3: begin a = 32'h7F800000; b = 32'h3F800000; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            send(a, b, t);
            if (i > 0) check("stream_interval", t - tp, 3);
            tp = t;
        end
        wait_valid();
        tick();
        check("stream_txn", {16'd0, txn_count - 16'(base)}, 10);
        check("stream_q_empty", q.size(), 0);

        // Async reset one clock after accept drops the operation
        send(32'h3F800000, 32'h40000000, t);
        tick();
        reset = 0;
        void'(q.pop_back());
        #1;
        check("arst_valid", {31'd0, res_valid}, 0);
        check("arst_add_a", add_a, 0);
        check("arst_txn", {16'd0, txn_count}, 0);
        tick();
        tick();
        check("arst_hold_valid", {31'd0, res_valid}, 0);
        reset = 1;
        tick();
        send(32'h7F800000, 32'h3F800000, t);
        wait_valid();
        tick();
        check("post_rst_txn", {16'd0, txn_count}, 1);
        check("final_q_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
